dmem_responder: RTL and testbench

Data-memory responder serving the pipelined core's load/store port: accepts the execute-stage address, store data, store-enable and load-enable, and returns the raw aligned word the Load Unit later sign/zero-extends. Stores retire into a small posted store buffer that drains into a single-port word SRAM during cycles without a load. Loads see buffered stores through byte-granular forwarding. A full buffer back-pressures the core with `stall`.

---
 rtl/dmem_responder.sv | 166 ++++++++++++++++
 tb/tb_dmem_responder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: load/store port of the data memory. Stores are posted into
// a small store buffer that drains into a single-port word SRAM on cycles
// without a load. Loads forward buffered bytes (youngest wins) and return a
// registered 32-bit word one cycle after the request.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned SB_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_we,
  input  logic        mem_re,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign,
  output logic        sb_empty
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned PW = $clog2(SB_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  // Word-addressed SRAM (contents survive reset)
  logic [31:0]   mem_q [DEPTH_WORDS];

  // Store-buffer entries
  logic [AW-1:0] sb_idx_q  [SB_DEPTH];
  logic [31:0]   sb_data_q [SB_DEPTH];
  logic [3:0]    sb_mask_q [SB_DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          misalign_q, misalign_d;

  logic [AW-1:0] idx;
  logic [3:0]    mask;
  logic          aligned;
  logic          bad_req;
  logic          push;
  logic          load;
  logic          drain;
  logic [31:0]   merged;
  logic [PW-1:0] slot;
  logic          unused_bits;

  assign idx         = addr[AW+1:2];
  assign unused_bits = ^{addr[31:AW+2], funct3[2]};

  // Byte-lane mask and alignment check from access size and offset
  always_comb begin
    mask    = 4'b0000;
    aligned = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        mask    = 4'b0001 << addr[1:0];
        aligned = 1'b1;
      end
      2'b01: begin
        mask    = 4'b0011 << addr[1:0];
        aligned = ~addr[0];
      end
      2'b10: begin
        mask    = 4'b1111;
        aligned = (addr[1:0] == 2'b00);
      end
      default: begin
        mask    = 4'b0000;
        aligned = 1'b0;
      end
    endcase
  end

  // Request classification. The SRAM port is treated as busy whenever mem_re
  // is raised (even alongside a store) and on any misaligned request, so the
  // buffer can only fill while the core keeps loads pending and a dropped
  // request leaves the buffer untouched.
  always_comb begin
    bad_req = (mem_we | mem_re) & ~aligned;
    push    = mem_we & aligned & ~stall;
    load    = mem_re & ~mem_we & aligned;
    drain   = (count_q != '0) & ~mem_re & ~bad_req;
  end

  // Load data: SRAM word overlaid oldest-to-youngest by matching buffer bytes
  always_comb begin
    merged = mem_q[idx];
    slot   = '0;
    for (int unsigned k = 0; k < SB_DEPTH; k++) begin
      slot = head_q + PW'(k);
      if ((CW'(k) < count_q) && (sb_idx_q[slot] == idx)) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (sb_mask_q[slot][b]) begin
            merged[8*b +: 8] = sb_data_q[slot][8*b +: 8];
          end
        end
      end
    end
  end

  // Next-state for pointers, occupancy, read data and misalign pulse
  always_comb begin
    head_d     = drain ? head_q + PTR_ONE : head_q;
    tail_d     = push  ? tail_q + PTR_ONE : tail_q;
    count_d    = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, drain};
    rdata_d    = load ? merged : rdata_q;
    misalign_d = bad_req;
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
    end
  end

  // Store-buffer entry write at the tail on an accepted store
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < SB_DEPTH; k++) begin
        sb_idx_q[k]  <= '0;
        sb_data_q[k] <= '0;
        sb_mask_q[k] <= '0;
      end
    end else if (push) begin
      sb_idx_q[tail_q]  <= idx;
      sb_data_q[tail_q] <= wdata;
      sb_mask_q[tail_q] <= mask;
    end
  end

  // SRAM byte-masked write of the head entry during a drain
  always_ff @(posedge clk) begin
    if (drain) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (sb_mask_q[head_q][b]) begin
          mem_q[sb_idx_q[head_q]][8*b +: 8] <= sb_data_q[head_q][8*b +: 8];
        end
      end
    end
  end

  // Outputs
  always_comb begin
    rdata    = rdata_q;
    misalign = misalign_q;
    stall    = (count_q == CW'(SB_DEPTH));
    sb_empty = (count_q == '0);
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed scenarios plus a randomized run
// checked against a byte-array memory and a queue of pending stores.
module tb_dmem_responder;

  localparam int unsigned DW  = 1024;
  localparam int unsigned SBD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_we;
  logic        mem_re;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        misalign;
  logic        sb_empty;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DW), .SB_DEPTH(SBD)) dut (
    .clk(clk), .rst(rst), .mem_we(mem_we), .mem_re(mem_re), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
    .misalign(misalign), .sb_empty(sb_empty)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct {
    int unsigned idx;
    logic [31:0] data;
    logic [3:0]  mask;
  } st_t;

  st_t         pend[$];
  logic [7:0]  ref_mem [DW*4];
  logic [31:0] ref_rdata;
  logic        ref_misalign;
  logic [31:0] pre_word [64];

  // Reference: apply the request currently on the inputs as one clock edge
  task automatic model_edge();
    int unsigned nbytes, off, wi;
    bit          ok, full;
    logic [3:0]  m;
    logic [31:0] w;
    st_t         e;
    off = addr % 4;
    wi  = (addr / 4) % DW;
    case (funct3[1:0])
      2'b00:   nbytes = 1;
      2'b01:   nbytes = 2;
      2'b10:   nbytes = 4;
      default: nbytes = 0;
    endcase
    ok = 1'b0;
    if (nbytes != 0) ok = ((off % nbytes) == 0);
    m = ok ? 4'(((32'd1 << nbytes) - 1) << off) : 4'b0000;
    full = (pend.size() == SBD);
    ref_misalign = (mem_we || mem_re) && !ok;
    if (mem_re && !mem_we && ok) begin
      for (int b = 0; b < 4; b++) w[8*b +: 8] = ref_mem[wi*4 + b];
      foreach (pend[i])
        if (pend[i].idx == wi)
          for (int b = 0; b < 4; b++)
            if (pend[i].mask[b]) w[8*b +: 8] = pend[i].data[8*b +: 8];
      ref_rdata = w;
    end else if (!mem_re && !ref_misalign && pend.size() > 0) begin
      e = pend.pop_front();
      for (int b = 0; b < 4; b++)
        if (e.mask[b]) ref_mem[e.idx*4 + b] = e.data[8*b +: 8];
    end
    if (mem_we && ok && !full) begin
      e.idx = wi; e.data = wdata; e.mask = m;
      pend.push_back(e);
    end
  endtask

  task automatic drive(input logic we, input logic re, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    mem_we = we; mem_re = re; funct3 = f3; addr = a; wdata = wd;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    repeat (n) step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want %h", rdata, 32'h0); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_cmp++; if (sb_empty !== 1'b1) begin n_bad++; $display("FAIL reset_sb_empty: got %b want 1", sb_empty); end
    n_cmp++; if (misalign !== 1'b0) begin n_bad++; $display("FAIL reset_misalign: got %b want 0", misalign); end
    ref_rdata = 32'h0; ref_misalign = 1'b0; pend.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic preload();
    for (int i = 0; i < 64; i++) begin
      pre_word[i] = $urandom;
      drive(1'b1, 1'b0, 3'b010, 32'(i * 4), pre_word[i]);
      step();
    end
    idle(2);
  endtask

  task automatic test_reset_pending();
    drive(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'h0);
    step();
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0014, 32'hCAFE_F00D);
    step();
    drive(1'b1, 1'b1, 3'b010, 32'h0000_0018, 32'hCAFE_F00E);
    step();
    drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    n_cmp++; if (sb_empty !== 1'b0) begin n_bad++; $display("FAIL rstp_pending: got %b want 0", sb_empty); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rstp_rdata: got %h want %h", rdata, 32'h0); end
    n_cmp++; if (sb_empty !== 1'b1) begin n_bad++; $display("FAIL rstp_sb_empty: got %b want 1", sb_empty); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rstp_stall: got %b want 0", stall); end
    ref_rdata = 32'h0; ref_misalign = 1'b0; pend.delete();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b1, 3'b010, 32'h0000_0014, 32'h0);
    step();
    n_cmp++; if (rdata !== pre_word[5]) begin n_bad++; $display("FAIL rstp_discard: got %h want %h", rdata, pre_word[5]); end
  endtask

  task automatic test_forward();
    idle(2);
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF);
    step();
    drive(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'h0);
    step();
    n_cmp++; if (rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL fwd_rdata: got %h want %h", rdata, 32'hDEAD_BEEF); end
    n_cmp++; if (sb_empty !== 1'b0) begin n_bad++; $display("FAIL fwd_not_drained: got %b want 0", sb_empty); end
    idle(2);
    n_cmp++; if (sb_empty !== 1'b1) begin n_bad++; $display("FAIL fwd_drained: got %b want 1", sb_empty); end
    drive(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'h0);
    step();
    n_cmp++; if (rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL fwd_sram: got %h want %h", rdata, 32'hDEAD_BEEF); end
  endtask

  task automatic test_merge();
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'h1122_3344); step();
    drive(1'b1, 1'b0, 3'b000, 32'h0000_0020, 32'h0000_00AA); step();
    drive(1'b1, 1'b0, 3'b001, 32'h0000_0022, 32'hBBBB_0000); step();
    drive(1'b0, 1'b1, 3'b010, 32'h0000_0020, 32'h0);         step();
    n_cmp++; if (rdata !== 32'hBBBB_33AA) begin n_bad++; $display("FAIL merge_rdata: got %h want %h", rdata, 32'hBBBB_33AA); end
  endtask

  task automatic test_stall();
    idle(2);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 3'b010, 32'(32'h50 + i * 4), 32'(32'h1000_0000 + i));
      step();
    end
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL stall_full: got %b want 1", stall); end
    drive(1'b1, 1'b1, 3'b010, 32'h0000_0060, 32'h5555_5555);
    repeat (2) begin
      step();
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL stall_held: got %b want 1", stall); end
    end
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0060, 32'h5555_5555);
    step();
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL stall_release: got %b want 0", stall); end
    step();
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL stall_accept: got %b want 0", stall); end
    idle(6);
    n_cmp++; if (sb_empty !== 1'b1) begin n_bad++; $display("FAIL stall_drained: got %b want 1", sb_empty); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 3'b010, 32'(32'h50 + i * 4), 32'h0);
      step();
      n_cmp++; if (rdata !== 32'(32'h1000_0000 + i)) begin n_bad++; $display("FAIL stall_word%0d: got %h want %h", i, rdata, 32'(32'h1000_0000 + i)); end
    end
    drive(1'b0, 1'b1, 3'b010, 32'h0000_0060, 32'h0);
    step();
    n_cmp++; if (rdata !== 32'h5555_5555) begin n_bad++; $display("FAIL stall_fifth: got %h want %h", rdata, 32'h5555_5555); end
  endtask

  task automatic test_misalign();
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0030, 32'h7777_7777);
    step();
    n_cmp++; if (misalign !== 1'b0) begin n_bad++; $display("FAIL mis_none: got %b want 0", misalign); end
    drive(1'b1, 1'b0, 3'b001, 32'h0000_0031, 32'h1234_5678);
    step();
    n_cmp++; if (misalign !== 1'b1) begin n_bad++; $display("FAIL mis_store: got %b want 1", misalign); end
    n_cmp++; if (sb_empty !== 1'b0) begin n_bad++; $display("FAIL mis_store_count: got %b want 0", sb_empty); end
    n_cmp++; if (rdata !== 32'h5555_5555) begin n_bad++; $display("FAIL mis_store_rdata: got %h want %h", rdata, 32'h5555_5555); end
    drive(1'b0, 1'b1, 3'b010, 32'h0000_0022, 32'h0);
    step();
    n_cmp++; if (misalign !== 1'b1) begin n_bad++; $display("FAIL mis_load: got %b want 1", misalign); end
    n_cmp++; if (sb_empty !== 1'b0) begin n_bad++; $display("FAIL mis_load_count: got %b want 0", sb_empty); end
    n_cmp++; if (rdata !== 32'h5555_5555) begin n_bad++; $display("FAIL mis_load_rdata: got %h want %h", rdata, 32'h5555_5555); end
    idle(1);
    n_cmp++; if (misalign !== 1'b0) begin n_bad++; $display("FAIL mis_pulse_end: got %b want 0", misalign); end
    drive(1'b0, 1'b1, 3'b010, 32'h0000_0030, 32'h0);
    step();
    n_cmp++; if (rdata !== 32'h7777_7777) begin n_bad++; $display("FAIL mis_word_kept: got %h want %h", rdata, 32'h7777_7777); end
  endtask

  task automatic test_both();
    drive(1'b1, 1'b1, 3'b010, 32'h0000_0040, 32'h5A5A_5A5A);
    step();
    n_cmp++; if (rdata !== 32'h7777_7777) begin n_bad++; $display("FAIL both_rdata_hold: got %h want %h", rdata, 32'h7777_7777); end
    n_cmp++; if (sb_empty !== 1'b0) begin n_bad++; $display("FAIL both_accepted: got %b want 0", sb_empty); end
    idle(2);
    drive(1'b0, 1'b1, 3'b010, 32'h0000_0040, 32'h0);
    step();
    n_cmp++; if (rdata !== 32'h5A5A_5A5A) begin n_bad++; $display("FAIL both_load: got %h want %h", rdata, 32'h5A5A_5A5A); end
  endtask

  task automatic test_random();
    int unsigned sz, off;
    logic [2:0]  f3;
    for (int c = 0; c < 400; c++) begin
      if (pend.size() == SBD && mem_we) begin
        mem_re = ($urandom_range(0, 3) != 0);
      end else begin
        sz  = ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, 2);
        f3  = {1'($urandom_range(0, 1)), 2'(sz)};
        off = $urandom_range(0, 3);
        if (sz == 1 && $urandom_range(0, 9) != 0) off = off & 2;
        if (sz == 2 && $urandom_range(0, 9) != 0) off = 0;
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), f3,
              ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63) * 4 + off),
              $urandom);
      end
      step();
      n_cmp++; if (rdata !== ref_rdata) begin n_bad++; $display("FAIL rand_rdata c%0d: got %h want %h", c, rdata, ref_rdata); end
      n_cmp++; if (misalign !== ref_misalign) begin n_bad++; $display("FAIL rand_misalign c%0d: got %b want %b", c, misalign, ref_misalign); end
      n_cmp++; if (stall !== (pend.size() == SBD)) begin n_bad++; $display("FAIL rand_stall c%0d: got %b want %b", c, stall, pend.size() == SBD); end
      n_cmp++; if (sb_empty !== (pend.size() == 0)) begin n_bad++; $display("FAIL rand_sb_empty c%0d: got %b want %b", c, sb_empty, pend.size() == 0); end
    end
  endtask

  initial begin
    test_reset();
    preload();
    test_reset_pending();
    test_forward();
    test_merge();
    test_stall();
    test_misalign();
    test_both();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
